// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and R/W bit values.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_tgt_state_t;

    // R/W bit in the address byte; the master block uses the same values.
    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer for one asynchronous bus line plus edge detection on the
// synchronized level. Resets to 1 because an idle I2C line is pulled high.
module i2c_sync_edge #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_FF-1:0] chain_q;
    logic               hist_q;

    // Shift the pad through the synchronizer chain, then one history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '1;
            hist_q  <= 1'b1;
        end else begin
            chain_q <= {chain_q[SYNC_FF-2:0], pad};
            hist_q  <= chain_q[SYNC_FF-1];
        end
    end

    assign level = chain_q[SYNC_FF-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target responding at one 7-bit address, exposing an 8-bit register
// space. Register port protocol: reg_we is a one-cycle strobe with no
// back-pressure; reg_addr/reg_wdata are valid in the strobe cycle and the
// external memory must accept the write in that cycle. reg_rdata is a
// combinational read of register[reg_addr], sampled whenever a byte is loaded.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h39,
    parameter int         SYNC_FF  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_oe,
    output logic [7:0]     reg_addr,
    output logic [7:0]     reg_wdata,
    output logic           reg_we,
    input  logic [7:0]     reg_rdata,
    output logic           busy,
    output i2c_tgt_state_t dbg_state
);

    logic s_scl, s_sda, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_tgt_state_t state;
    logic [7:0]     shift_q;
    logic [3:0]     bit_cnt;
    logic           ptr_phase;
    logic           rw_q;
    logic           inc_pend;
    logic           load_pend;
    logic [7:0]     byte_in;

    i2c_sync_edge #(.SYNC_FF(SYNC_FF)) u_scl (
        .clk   (clk),
        .rst   (rst),
        .pad   (scl_in),
        .level (s_scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_FF(SYNC_FF)) u_sda (
        .clk   (clk),
        .rst   (rst),
        .pad   (sda_in),
        .level (s_sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_evt = s_scl & sda_fall;
    assign stop_evt  = s_scl & sda_rise;
    assign byte_in   = {shift_q[6:0], s_sda};
    assign dbg_state = state;

    // Protocol FSM: START/STOP first, then per-state bit handling on SCL edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= 8'h00;
            bit_cnt   <= 4'd0;
            ptr_phase <= 1'b0;
            rw_q      <= I2C_WR;
            inc_pend  <= 1'b0;
            load_pend <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            // Pointer advances the cycle after a write strobe so the strobe
            // carries the address the byte belongs to.
            if (inc_pend) begin
                reg_addr <= reg_addr + 8'd1;
                inc_pend <= 1'b0;
            end
            // Next read byte is fetched once the incremented pointer is visible.
            if (load_pend) begin
                shift_q   <= reg_rdata;
                load_pend <= 1'b0;
            end

            if (start_evt) begin
                state     <= ADDR;
                bit_cnt   <= 4'd0;
                shift_q   <= 8'h00;
                sda_oe    <= 1'b0;
                load_pend <= 1'b0;
            end else if (stop_evt) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                load_pend <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= byte_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                if (byte_in[7:1] == I2C_ADDR) begin
                                    state <= ADDR_ACK;
                                    rw_q  <= byte_in[0];
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        // sda_oe doubles as the "ACK already driven" marker.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                            end else if (rw_q == I2C_RD) begin
                                sda_oe  <= ~reg_rdata[7];
                                shift_q <= {reg_rdata[6:0], 1'b0};
                                bit_cnt <= 4'd1;
                                state   <= RD_BYTE;
                            end else begin
                                sda_oe    <= 1'b0;
                                bit_cnt   <= 4'd0;
                                ptr_phase <= 1'b1;
                                state     <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q <= byte_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                state   <= WR_ACK;
                                if (ptr_phase) begin
                                    reg_addr  <= byte_in;
                                    ptr_phase <= 1'b0;
                                end else begin
                                    reg_wdata <= byte_in;
                                    reg_we    <= 1'b1;
                                    inc_pend  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_BYTE;
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RD_ACK;
                            end else begin
                                sda_oe  <= ~shift_q[7];
                                shift_q <= {shift_q[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!s_sda) begin
                                reg_addr  <= reg_addr + 8'd1;
                                load_pend <= 1'b1;
                                state     <= RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    IDLE, IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
